piso: RTL and testbench

Parallel-in, serial-out shift register. Captures a WIDTH-bit parallel word on a load strobe and shifts it out one bit per clock on a single serial line. Sits between parallel datapath logic and a serial link or serial peripheral interface. Provides busy/done status so upstream logic knows when the next word may be loaded.

---
 rtl/piso.sv | 67 ++++++
 tb/tb_piso.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/piso.sv
// Parallel-in, serial-out shift register with busy/done status.
// A word captured on load_i appears on out_o starting at the very next clock phase; one bit
// leaves per clock, with FILL entering the vacated end.
module piso #(
   parameter int unsigned WIDTH     = 4,
   parameter bit          MSB_FIRST = 1'b1,
   parameter bit          FILL      = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [WIDTH-1:0] in_i,
   output logic             out_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int unsigned     CntW    = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] CntFull = CntW'(WIDTH);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] shifted;

   // Register contents after one shift toward the head, fill entering the far end.
   assign shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], FILL} : {FILL, sreg_q[WIDTH-1:1]};

   // Next state: load overrides shifting; shifting continues even once the word is gone.
   always_comb begin
      sreg_d = shifted;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (load_i) begin
         sreg_d = in_i;
         cnt_d  = CntFull;
      end else begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - CntOne;
         end
         // Last data bit leaves the head on this edge.
         done_d = (cnt_q == CntOne);
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sreg_q <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         sreg_q <= sreg_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   // Head bit drives the line directly, no output register.
   always_comb begin
      out_o  = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
      busy_o = (cnt_q != '0);
      done_o = done_q;
   end

endmodule

// File: tb/tb_piso.sv
// Bench for piso: three configurations share one stimulus stream and are compared against a
// model that tracks the loaded word and how many shifts have happened since it was loaded.
module tb_piso;

   localparam int unsigned W = 4;

   logic         clk;
   logic         rst_n;
   logic         ld;
   logic [W-1:0] din;

   logic out_a, busy_a, done_a;  // MSB first, fill 0
   logic out_b, busy_b, done_b;  // LSB first, fill 0
   logic out_c, busy_c, done_c;  // MSB first, fill 1

   piso #(.WIDTH(W), .MSB_FIRST(1'b1), .FILL(1'b0)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .load_i(ld), .in_i(din),
      .out_o(out_a), .busy_o(busy_a), .done_o(done_a)
   );
   piso #(.WIDTH(W), .MSB_FIRST(1'b0), .FILL(1'b0)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .load_i(ld), .in_i(din),
      .out_o(out_b), .busy_o(busy_b), .done_o(done_b)
   );
   piso #(.WIDTH(W), .MSB_FIRST(1'b1), .FILL(1'b1)) dut_c (
      .clk_i(clk), .rst_ni(rst_n), .load_i(ld), .in_i(din),
      .out_o(out_c), .busy_o(busy_c), .done_o(done_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: last loaded word, shifts since load (saturating at W), whether a word was loaded
   // since reset, and the registered done pulse.
   logic [W-1:0] m_w;
   int           m_k;
   bit           m_valid;
   bit           m_done;

   function automatic logic m_head(input bit msb, input bit fill);
      if (m_k < W) return msb ? m_w[W-1-m_k] : m_w[m_k];
      return fill;
   endfunction

   function automatic logic m_busy();
      return m_valid && (m_k < W);
   endfunction

   task automatic m_reset();
      m_w     = '0;
      m_k     = 0;
      m_valid = 1'b0;
      m_done  = 1'b0;
   endtask

   task automatic m_edge(input logic l, input logic [W-1:0] d);
      if (l) begin
         m_w     = d;
         m_k     = 0;
         m_valid = 1'b1;
         m_done  = 1'b0;
      end else begin
         m_done = m_valid && (m_k == W - 1);
         if (m_k < W) m_k++;
      end
   endtask

   task automatic cmp(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %b want %b", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      cmp({tag, " a.out"},  out_a,  m_head(1'b1, 1'b0));
      cmp({tag, " a.busy"}, busy_a, m_busy());
      cmp({tag, " a.done"}, done_a, m_done);
      cmp({tag, " b.out"},  out_b,  m_head(1'b0, 1'b0));
      cmp({tag, " b.busy"}, busy_b, m_busy());
      cmp({tag, " b.done"}, done_b, m_done);
      cmp({tag, " c.out"},  out_c,  m_head(1'b1, 1'b1));
      cmp({tag, " c.busy"}, busy_c, m_busy());
      cmp({tag, " c.done"}, done_c, m_done);
   endtask

   // Drive inputs away from the edge, clock once, then check 1 time unit after the edge.
   task automatic cycle(input string tag, input logic l, input logic [W-1:0] d);
      ld  = l;
      din = d;
      @(posedge clk);
      m_edge(l, d);
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic async_reset(input string tag);
      rst_n = 1'b0;
      m_reset();
      #1;
      check_all({tag, " rst"});
      #1;
      rst_n = 1'b1;
      #1;
      check_all({tag, " rel"});
   endtask

   logic [7:0] seq;

   initial begin
      m_reset();
      rst_n = 1'b0;
      ld    = 1'b0;
      din   = '1;
      #2;
      check_all("t1 async");
      // Reset held across edges with load toggling and in=1111.
      for (int i = 0; i < 4; i++) begin
         ld  = i[0];
         din = 4'b1111;
         @(posedge clk);
         #1;
         check_all("t1 held");
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_all("t1 release");

      // Basic shift of 1001, also against the literal serial sequence.
      seq = 8'b1001_0000;
      cycle("t2 ld0", 1'b1, 4'b0000);
      cycle("t2 ld", 1'b1, 4'b1001);
      cmp("t2 seq0", out_a, seq[7]);
      cmp("t2 busy0", busy_a, 1'b1);
      for (int i = 1; i < 8; i++) begin
         cycle("t2 sh", 1'b0, 4'b0000);
         cmp("t2 seq", out_a, seq[7-i]);
         cmp("t2 busy", busy_a, (i < 4) ? 1'b1 : 1'b0);
         cmp("t2 done", done_a, (i == 4) ? 1'b1 : 1'b0);
      end

      // Asymmetric word 1100 through all three configurations, then drain.
      cycle("t3 ld", 1'b1, 4'b1100);
      for (int i = 0; i < 7; i++) cycle("t3 sh", 1'b0, 4'b0000);

      // Reload mid-word: old word is abandoned without a done pulse.
      cycle("t4 ld1", 1'b1, 4'b1010);
      cycle("t4 sh", 1'b0, 4'b0000);
      cycle("t4 sh", 1'b0, 4'b0000);
      cycle("t4 ld2", 1'b1, 4'b0111);
      for (int i = 0; i < 6; i++) cycle("t4 sh2", 1'b0, 4'b0000);

      // Reload on the edge where done would have fired.
      cycle("t4b ld", 1'b1, 4'b1011);
      for (int i = 0; i < 3; i++) cycle("t4b sh", 1'b0, 4'b0000);
      cycle("t4b reld", 1'b1, 4'b0110);
      cmp("t4b nodone", done_a, 1'b0);
      for (int i = 0; i < 5; i++) cycle("t4b sh2", 1'b0, 4'b0000);

      // Reset mid-shift: outputs drop at once and no done follows.
      cycle("t5 ld", 1'b1, 4'b1001);
      cycle("t5 sh", 1'b0, 4'b0000);
      async_reset("t5");
      cmp("t5 out0", out_a, 1'b0);
      for (int i = 0; i < 6; i++) cycle("t5 sh", 1'b0, 4'b0000);

      // Held load with changing data.
      cycle("t6 ld", 1'b1, 4'b1000);
      cycle("t6 ld", 1'b1, 4'b1000);
      cycle("t6 ld", 1'b1, 4'b0001);
      cmp("t6 out", out_a, 1'b0);
      cycle("t6 ld", 1'b1, 4'b0001);
      cycle("t6 ld", 1'b1, 4'b1111);
      cmp("t6 busy", busy_a, 1'b1);
      for (int i = 0; i < 6; i++) cycle("t6 sh", 1'b0, 4'b0000);

      // Randomized traffic with occasional mid-cycle resets.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            async_reset("rnd");
         end else begin
            cycle("rnd", ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, W'($urandom));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
